// File: rtl/ctrl_pkg.sv
// Shared opcode, ALU-function, state and instruction-class definitions for the control unit.
package ctrl_pkg;

    localparam int unsigned OPC_W   = 6;
    localparam int unsigned FUNC_W  = 4;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned INSTR_W = 32;

    // Opcodes (Instr[31:26])
    localparam logic [OPC_W-1:0] OP_RTYPE = 6'b100000;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'b110000;
    localparam logic [OPC_W-1:0] OP_ANDI  = 6'b110010;
    localparam logic [OPC_W-1:0] OP_ORI   = 6'b110011;
    localparam logic [OPC_W-1:0] OP_B     = 6'b111111;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'b010000;
    localparam logic [OPC_W-1:0] OP_BNE   = 6'b010001;
    localparam logic [OPC_W-1:0] OP_LW    = 6'b001111;
    localparam logic [OPC_W-1:0] OP_SW    = 6'b011111;

    // ALU function codes
    localparam logic [FUNC_W-1:0] ALU_ADD = 4'b0000;
    localparam logic [FUNC_W-1:0] ALU_SUB = 4'b0001;
    localparam logic [FUNC_W-1:0] ALU_AND = 4'b0010;
    localparam logic [FUNC_W-1:0] ALU_OR  = 4'b0011;

    // Sequencer states; encoding is visible on the State debug port
    typedef enum logic [STATE_W-1:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        BRANCH = 3'd5,
        HALT   = 3'd7
    } state_t;

    // Instruction classes produced by the decoder
    typedef enum logic [2:0] {
        ALU_R   = 3'd0,
        ALU_I   = 3'd1,
        LOAD    = 3'd2,
        STORE   = 3'd3,
        BR_U    = 3'd4,
        BR_EQ   = 3'd5,
        BR_NE   = 3'd6,
        ILLEGAL = 3'd7
    } iclass_t;

    // Decoded instruction payload handed from decoder to sequencer
    typedef struct packed {
        iclass_t             iclass;
        logic [FUNC_W-1:0]   alu_func;
    } decode_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder: opcode/func field to instruction class and ALU operation.
module instr_decode
    import ctrl_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output decode_t            dec_c
);

    logic [OPC_W-1:0]  opcode;
    logic [FUNC_W-1:0] func;
    logic              unused_bits;

    assign opcode      = instr[31:26];
    assign func        = instr[3:0];
    assign unused_bits = ^instr[25:4];

    // Class and ALU function lookup; memory ops use add for address, branches compare with sub
    always_comb begin
        dec_c.iclass   = ILLEGAL;
        dec_c.alu_func = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin dec_c.iclass = ALU_R; dec_c.alu_func = func;    end
            OP_ADDI:  begin dec_c.iclass = ALU_I; dec_c.alu_func = ALU_ADD; end
            OP_ANDI:  begin dec_c.iclass = ALU_I; dec_c.alu_func = ALU_AND; end
            OP_ORI:   begin dec_c.iclass = ALU_I; dec_c.alu_func = ALU_OR;  end
            OP_LW:    begin dec_c.iclass = LOAD;  dec_c.alu_func = ALU_ADD; end
            OP_SW:    begin dec_c.iclass = STORE; dec_c.alu_func = ALU_ADD; end
            OP_B:     begin dec_c.iclass = BR_U;  dec_c.alu_func = ALU_SUB; end
            OP_BEQ:   begin dec_c.iclass = BR_EQ; dec_c.alu_func = ALU_SUB; end
            OP_BNE:   begin dec_c.iclass = BR_NE; dec_c.alu_func = ALU_SUB; end
            default:  begin dec_c.iclass = ILLEGAL; dec_c.alu_func = ALU_ADD; end
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle datapath control: sequences each instruction and drives all datapath control inputs.
module control_fsm #(
    parameter bit IDLE_ON_ILLEGAL = 1'b0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Instr,
    input  logic        Zero,
    output logic        PC_Sel,
    output logic        PC_LdEn,
    output logic        RF_WrEn,
    output logic        RF_WrData_sel,
    output logic        RF_B_sel,
    output logic        ALU_Bin_sel,
    output logic [3:0]  ALU_func,
    output logic        Mem_WrEn,
    output logic        Illegal,
    output logic [2:0]  State
);

    import ctrl_pkg::*;

    state_t  state_q;
    state_t  state_d;
    decode_t dec;
    logic    is_imm;
    logic    is_mem;

    instr_decode u_decode (
        .instr (Instr),
        .dec_c (dec)
    );

    assign is_mem = (dec.iclass == LOAD) || (dec.iclass == STORE);
    assign is_imm = (dec.iclass == ALU_I) || is_mem;

    // State register with synchronous reset back to FETCH
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing by instruction class
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (dec.iclass)
                    ALU_R, ALU_I, LOAD, STORE: state_d = EXEC;
                    BR_U, BR_EQ, BR_NE:        state_d = BRANCH;
                    default:                   state_d = IDLE_ON_ILLEGAL ? HALT : FETCH;
                endcase
            end
            EXEC:   state_d = is_mem ? MEM : WB;
            MEM:    state_d = (dec.iclass == LOAD) ? WB : FETCH;
            WB:     state_d = FETCH;
            BRANCH: state_d = FETCH;
            HALT:   state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // Control outputs from state, decoded class and Zero; all forced low while Reset is high
    always_comb begin
        PC_Sel        = 1'b0;
        PC_LdEn       = 1'b0;
        RF_WrEn       = 1'b0;
        RF_WrData_sel = 1'b0;
        RF_B_sel      = 1'b0;
        ALU_Bin_sel   = 1'b0;
        ALU_func      = ALU_ADD;
        Mem_WrEn      = 1'b0;
        Illegal       = 1'b0;
        State         = 3'd0;
        if (!Reset) begin
            State = 3'(state_q);
            case (state_q)
                DECODE: begin
                    if (dec.iclass == ILLEGAL) begin
                        Illegal = 1'b1;
                        PC_LdEn = !IDLE_ON_ILLEGAL;
                    end
                end
                EXEC: begin
                    ALU_func    = dec.alu_func;
                    ALU_Bin_sel = is_imm;
                    RF_B_sel    = (dec.iclass == STORE);
                end
                MEM: begin
                    ALU_func    = ALU_ADD;
                    ALU_Bin_sel = 1'b1;
                    if (dec.iclass == STORE) begin
                        RF_B_sel = 1'b1;
                        Mem_WrEn = 1'b1;
                        PC_LdEn  = 1'b1;
                    end
                end
                WB: begin
                    ALU_func      = dec.alu_func;
                    ALU_Bin_sel   = is_imm;
                    RF_WrEn       = 1'b1;
                    PC_LdEn       = 1'b1;
                    RF_WrData_sel = (dec.iclass == LOAD);
                end
                BRANCH: begin
                    ALU_func    = ALU_SUB;
                    ALU_Bin_sel = 1'b0;
                    RF_B_sel    = 1'b1;
                    PC_LdEn     = 1'b1;
                    case (dec.iclass)
                        BR_U:    PC_Sel = 1'b1;
                        BR_EQ:   PC_Sel = Zero;
                        BR_NE:   PC_Sel = !Zero;
                        default: PC_Sel = 1'b0;
                    endcase
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
// Directed scoreboard bench for control_fsm, one instance per IDLE_ON_ILLEGAL setting.
module tb_control_fsm;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] Instr;
    logic        Zero;

    logic       n_pc_sel, n_pc_ld, n_rf_wr, n_wd_sel, n_b_sel, n_bin_sel, n_mem_wr, n_ill;
    logic [3:0] n_func;
    logic [2:0] n_state;
    logic       h_pc_sel, h_pc_ld, h_rf_wr, h_wd_sel, h_b_sel, h_bin_sel, h_mem_wr, h_ill;
    logic [3:0] h_func;
    logic [2:0] h_state;

    logic [14:0] vec_n, vec_h;

    typedef struct {
        logic [14:0] en;
        logic [14:0] eh;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    always #5 Clk = ~Clk;

    control_fsm #(.IDLE_ON_ILLEGAL(1'b0)) dut_n (
        .Clk(Clk), .Reset(Reset), .Instr(Instr), .Zero(Zero),
        .PC_Sel(n_pc_sel), .PC_LdEn(n_pc_ld), .RF_WrEn(n_rf_wr),
        .RF_WrData_sel(n_wd_sel), .RF_B_sel(n_b_sel), .ALU_Bin_sel(n_bin_sel),
        .ALU_func(n_func), .Mem_WrEn(n_mem_wr), .Illegal(n_ill), .State(n_state)
    );

    control_fsm #(.IDLE_ON_ILLEGAL(1'b1)) dut_h (
        .Clk(Clk), .Reset(Reset), .Instr(Instr), .Zero(Zero),
        .PC_Sel(h_pc_sel), .PC_LdEn(h_pc_ld), .RF_WrEn(h_rf_wr),
        .RF_WrData_sel(h_wd_sel), .RF_B_sel(h_b_sel), .ALU_Bin_sel(h_bin_sel),
        .ALU_func(h_func), .Mem_WrEn(h_mem_wr), .Illegal(h_ill), .State(h_state)
    );

    assign vec_n = {n_state, n_pc_sel, n_pc_ld, n_rf_wr, n_wd_sel, n_b_sel, n_bin_sel, n_func, n_mem_wr, n_ill};
    assign vec_h = {h_state, h_pc_sel, h_pc_ld, h_rf_wr, h_wd_sel, h_b_sel, h_bin_sel, h_func, h_mem_wr, h_ill};

    // Expected output vector, same field order as vec_n/vec_h
    function automatic logic [14:0] v(input logic [2:0] st, input logic pcs, input logic pcl,
                                      input logic rfw, input logic wds, input logic bs,
                                      input logic bin, input logic [3:0] fn,
                                      input logic mw, input logic il);
        return {st, pcs, pcl, rfw, wds, bs, bin, fn, mw, il};
    endfunction

    localparam logic [14:0] ZERO_V = 15'h0000;

    task automatic push(input logic [14:0] en, input logic [14:0] eh);
        exp_t e;
        e.en = en;
        e.eh = eh;
        sb.push_back(e);
    endtask

    task automatic push2(input logic [14:0] e);
        push(e, e);
    endtask

    task automatic check_now(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL %s: scoreboard empty when a result was due", tag);
            return;
        end
        e = sb.pop_front();
        compared++;
        assert (vec_n === e.en) else begin
            mismatched++;
            $error("FAIL %s dut_n: observed %h expected %h", tag, vec_n, e.en);
        end
        compared++;
        assert (vec_h === e.eh) else begin
            mismatched++;
            $error("FAIL %s dut_h: observed %h expected %h", tag, vec_h, e.eh);
        end
    endtask

    // Compare one cycle per queued entry; leaves the bench at the negedge of the next FETCH
    task automatic drain(input string tag);
        while (sb.size() > 0) begin
            check_now(tag);
            @(negedge Clk);
        end
    endtask

    task automatic run(input string tag, input logic [31:0] ins, input logic z);
        Instr = ins;
        Zero  = z;
        drain(tag);
    endtask

    // Hold Reset for n rising edges, checking all outputs are zero throughout
    task automatic do_reset(input string tag, input int n);
        Reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            push2(ZERO_V);
            check_now(tag);
            @(negedge Clk);
        end
        Reset = 1'b0;
    endtask

    task automatic push_alu(input logic [3:0] fn, input logic imm);
        push2(ZERO_V);
        push2(v(3'd1, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0));
        push2(v(3'd2, 0, 0, 0, 0, 0, imm, fn, 0, 0));
        push2(v(3'd4, 0, 1, 1, 0, 0, imm, fn, 0, 0));
    endtask

    task automatic push_br(input logic taken);
        push2(ZERO_V);
        push2(v(3'd1, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0));
        push2(v(3'd5, taken, 1, 0, 0, 1, 0, 4'b0001, 0, 0));
    endtask

    initial begin
        Reset = 1'b1;
        Instr = 32'h0;
        Zero  = 1'b0;
        @(negedge Clk);
        do_reset("init_reset", 3);

        // addi interrupted in EXEC by a 3-cycle reset
        Instr = 32'hC0000005;
        push2(ZERO_V);
        push2(v(3'd1, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0));
        push2(v(3'd2, 0, 0, 0, 0, 0, 1, 4'b0000, 0, 0));
        check_now("abort_fetch");  @(negedge Clk);
        check_now("abort_decode"); @(negedge Clk);
        check_now("abort_exec");
        do_reset("abort_reset", 3);

        // ALU instructions
        push_alu(4'b0001, 1'b0); run("rtype_sub", 32'h80000001, 1'b0);
        push_alu(4'b0011, 1'b0); run("rtype_or",  32'h80000003, 1'b1);
        push_alu(4'b0000, 1'b1); run("addi",      32'hC0000005, 1'b0);
        push_alu(4'b0010, 1'b1); run("andi",      32'hC8001234, 1'b1);
        push_alu(4'b0011, 1'b1); run("ori",       32'hCC00FFFF, 1'b0);

        // lw: 5 cycles, load data written back in WB
        push2(ZERO_V);
        push2(v(3'd1, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0));
        push2(v(3'd2, 0, 0, 0, 0, 0, 1, 4'b0000, 0, 0));
        push2(v(3'd3, 0, 0, 0, 0, 0, 1, 4'b0000, 0, 0));
        push2(v(3'd4, 0, 1, 1, 1, 0, 1, 4'b0000, 0, 0));
        run("lw", 32'h3C000004, 1'b0);

        // sw: 4 cycles, single memory write in MEM
        push2(ZERO_V);
        push2(v(3'd1, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0));
        push2(v(3'd2, 0, 0, 0, 0, 1, 1, 4'b0000, 0, 0));
        push2(v(3'd3, 0, 1, 0, 0, 1, 1, 4'b0000, 1, 0));
        run("sw", 32'h7C000004, 1'b1);

        // Branches
        push_br(1'b1); run("beq_z1", 32'h40000010, 1'b1);
        push_br(1'b0); run("beq_z0", 32'h40000010, 1'b0);
        push_br(1'b0); run("bne_z1", 32'h44000010, 1'b1);
        push_br(1'b1); run("bne_z0", 32'h44000010, 1'b0);
        push_br(1'b1); run("b_z0",   32'hFC000010, 1'b0);
        push_br(1'b1); run("b_z1",   32'hFC000010, 1'b1);

        // Illegal opcode: dut_n skips and refetches, dut_h parks in HALT
        push(ZERO_V, ZERO_V);
        push(v(3'd1, 0, 1, 0, 0, 0, 0, 4'b0000, 0, 1), v(3'd1, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 1));
        push(ZERO_V, v(3'd7, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0));
        push(v(3'd1, 0, 1, 0, 0, 0, 0, 4'b0000, 0, 1), v(3'd7, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0));
        push(ZERO_V, v(3'd7, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0));
        run("illegal", 32'h04000000, 1'b0);
        do_reset("halt_reset", 2);

        // Recovery after leaving HALT
        push_alu(4'b0000, 1'b0); run("rtype_add_after_halt", 32'h80000000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
